// File: rtl/si3000_sched_pkg.sv
// Shared definitions for the Si3000 frame scheduler.
//  - FSM state and frame-type enums
//  - control-word field positions (RW bit 13, ADDR 12:8, DATA 7:0)
//  - default playback FIFO depth
//  - register bundle of the scheduler and its reset value
//  - helper that assembles a secondary (control) word
package si3000_sched_pkg;

    localparam int TX_FIFO_DEPTH_DEFAULT = 4;

    localparam int CW_RW_BIT   = 13;
    localparam int CW_ADDR_MSB = 12;
    localparam int CW_ADDR_LSB = 8;
    localparam int CW_DATA_MSB = 7;
    localparam int CW_DATA_LSB = 0;

    typedef enum logic {
        S_PRI = 1'b0,   // primary (sample) word presented
        S_SEC = 1'b1    // control word presented
    } sched_state_e;

    typedef enum logic {
        FRAME_PRI = 1'b0,
        FRAME_SEC = 1'b1
    } frame_type_e;

    typedef struct packed {
        sched_state_e state;
        logic [15:0]  cwd;        // codec_write_data register
        logic         pend;       // register op waiting for its secondary frame
        logic         busy;
        logic         rw;         // request fields captured at acceptance
        logic [4:0]   addr;
        logic [7:0]   wdata;
        frame_type_e  frame;      // type of the last grasped frame
        logic         started;    // at least one grasp since reset
        logic         done_prev;  // codec_done delayed, for edge detection
        logic         underrun;
        logic [15:0]  rx_sample;
        logic         rx_valid;
        logic         reg_ack;
        logic [7:0]   reg_rdata;
    } sched_regs_t;

    localparam sched_regs_t SCHED_REGS_RESET = '{
        state:     S_PRI,
        cwd:       16'h0000,
        pend:      1'b0,
        busy:      1'b0,
        rw:        1'b0,
        addr:      5'd0,
        wdata:     8'h00,
        frame:     FRAME_PRI,
        started:   1'b0,
        done_prev: 1'b0,
        underrun:  1'b0,
        rx_sample: 16'h0000,
        rx_valid:  1'b0,
        reg_ack:   1'b0,
        reg_rdata: 8'h00
    };

    // Reads carry no data byte, so the data field is zeroed for rw=1.
    function automatic logic [15:0] make_ctrl_word(input logic       rw,
                                                   input logic [4:0] addr,
                                                   input logic [7:0] wdata);
        logic [15:0] w;
        w = 16'h0000;
        w[CW_RW_BIT]                 = rw;
        w[CW_ADDR_MSB:CW_ADDR_LSB]   = addr;
        w[CW_DATA_MSB:CW_DATA_LSB]   = rw ? 8'h00 : wdata;
        return w;
    endfunction

endpackage

// File: rtl/si3000_frame_scheduler_if.sv
// Bus bundle between the Si3000 frame scheduler, its host and the codec
// serial engine.
//  Playback : tx_sample, tx_valid (host->sched), tx_ready (sched->host)
//  Capture  : rx_sample, rx_valid (sched->host)
//  Registers: reg_req, reg_rw, reg_addr, reg_wdata (host->sched),
//             reg_busy, reg_ack, reg_rdata (sched->host)
//  Codec    : codec_write_data (sched->codec), codec_write_data_grasp,
//             codec_fsync, codec_read_data, codec_done (codec->sched)
//  Status   : underrun (sched->host)
// Modport slave is the scheduler's view; master is the environment's view.
interface si3000_frame_scheduler_if;

    logic [15:0] tx_sample;
    logic        tx_valid;
    logic        tx_ready;

    logic [15:0] rx_sample;
    logic        rx_valid;

    logic        reg_req;
    logic        reg_rw;
    logic [4:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_busy;
    logic        reg_ack;
    logic [7:0]  reg_rdata;

    logic [15:0] codec_write_data;
    logic        codec_write_data_grasp;
    logic        codec_fsync;
    logic [15:0] codec_read_data;
    logic        codec_done;

    logic        underrun;

    modport slave (
        input  tx_sample, tx_valid,
        output tx_ready,
        output rx_sample, rx_valid,
        input  reg_req, reg_rw, reg_addr, reg_wdata,
        output reg_busy, reg_ack, reg_rdata,
        output codec_write_data,
        input  codec_write_data_grasp, codec_fsync, codec_read_data, codec_done,
        output underrun
    );

    modport master (
        output tx_sample, tx_valid,
        input  tx_ready,
        input  rx_sample, rx_valid,
        output reg_req, reg_rw, reg_addr, reg_wdata,
        input  reg_busy, reg_ack, reg_rdata,
        input  codec_write_data,
        output codec_write_data_grasp, codec_fsync, codec_read_data, codec_done,
        input  underrun
    );

endinterface

// File: rtl/si3000_sample_fifo.sv
// Synchronous playback-sample FIFO with count-based full/empty.
//  clk, reset_n : clock, asynchronous active-low reset
//  flush_i      : synchronous clear of pointers and count
//  push_i/push_data_i : write strobe and data; ignored when full unless a
//                       pop happens in the same cycle
//  pop_i        : removes the head entry (ignored when empty)
//  head_o       : current head entry (meaningless while empty_o=1)
//  full_o, empty_o : occupancy flags
module si3000_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot this cycle, so a full FIFO can still take a push.
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; clearing pointers and count makes
    // stale contents unreachable, and a reset-free array can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/si3000_frame_scheduler.sv
// Si3000 frame scheduler: decides what word the codec serial engine sends
// in each frame and routes what comes back.
//  clk, reset_n : clock, asynchronous active-low reset
//  sync_reset   : synchronous flush of FSM, FIFO and pending register op
//  bus (slave)  : playback FIFO input, capture output, register request
//                 port, codec word/handshake signals and underrun flag
// Each frame is either primary (playback sample, LSB flags a pending
// register op) or secondary (control word built from the latched request).
// A rising codec_done completes the frame: primary frames yield a capture
// sample, secondary frames complete the register op with reg_ack.
module si3000_frame_scheduler
    import si3000_sched_pkg::*;
#(
    parameter int TX_FIFO_DEPTH = TX_FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    si3000_frame_scheduler_if.slave  bus
);

    sched_regs_t regs_q, regs_d;

    logic [15:0] fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [15:0] pri_word;
    logic [15:0] ctrl_word;
    logic        grasp;
    logic        done_rise;

    si3000_sample_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (sync_reset),
        .push_i      (bus.tx_valid),
        .push_data_i (bus.tx_sample),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign grasp     = bus.codec_write_data_grasp;
    assign done_rise = bus.codec_done && !regs_q.done_prev;

    // Primary word: head sample with its LSB replaced by the pending flag;
    // an empty FIFO sends silence.
    assign pri_word  = ((fifo_empty ? 16'h0000 : fifo_head) & 16'hFFFE)
                     | {15'd0, regs_q.pend};
    assign ctrl_word = make_ctrl_word(regs_q.rw, regs_q.addr, regs_q.wdata);

    always_comb begin
        regs_d           = regs_q;
        regs_d.rx_valid  = 1'b0;
        regs_d.reg_ack   = 1'b0;
        regs_d.done_prev = bus.codec_done;
        fifo_pop         = 1'b0;

        // Request fields are captured here so later input changes cannot
        // alter the control word.
        if (bus.reg_req && !regs_q.busy) begin
            regs_d.busy  = 1'b1;
            regs_d.pend  = 1'b1;
            regs_d.rw    = bus.reg_rw;
            regs_d.addr  = bus.reg_addr;
            regs_d.wdata = bus.reg_wdata;
        end

        case (regs_q.state)
            S_PRI: begin
                if (grasp) begin
                    regs_d.frame   = FRAME_PRI;
                    regs_d.started = 1'b1;
                    if (fifo_empty) regs_d.underrun = 1'b1;
                    else            fifo_pop        = 1'b1;
                    if (regs_q.cwd[0]) regs_d.state = S_SEC;
                end
            end
            S_SEC: begin
                if (grasp) begin
                    regs_d.frame   = FRAME_SEC;
                    regs_d.started = 1'b1;
                    regs_d.pend    = 1'b0;
                    regs_d.state   = S_PRI;
                end
            end
            default: regs_d.state = S_PRI;
        endcase

        // The word must hold steady while the codec is starting a frame or
        // sampling it; otherwise it tracks the current state's source.
        if (!bus.codec_fsync && !grasp) begin
            regs_d.cwd = (regs_q.state == S_PRI) ? pri_word : ctrl_word;
        end

        // Done edges before the first grasp belong to no frame we issued.
        if (done_rise && regs_q.started) begin
            if (regs_q.frame == FRAME_PRI) begin
                regs_d.rx_sample = bus.codec_read_data;
                regs_d.rx_valid  = 1'b1;
            end else begin
                regs_d.reg_ack = 1'b1;
                regs_d.busy    = 1'b0;
                if (regs_q.rw) regs_d.reg_rdata = bus.codec_read_data[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= SCHED_REGS_RESET;
        end else if (sync_reset) begin
            regs_q <= SCHED_REGS_RESET;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.codec_write_data = regs_q.cwd;
    assign bus.rx_sample        = regs_q.rx_sample;
    assign bus.rx_valid         = regs_q.rx_valid;
    assign bus.reg_busy         = regs_q.busy;
    assign bus.reg_ack          = regs_q.reg_ack;
    assign bus.reg_rdata        = regs_q.reg_rdata;
    assign bus.underrun         = regs_q.underrun;
    assign bus.tx_ready         = !fifo_full;

endmodule
